// File: rtl/fl_trim_pkg.sv
// Shared types and helpers for the FrameLink frame-trim stage.
// Imported by the interface, the output register and the top.
package fl_trim_pkg;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    DROP = 1'b1
  } state_e;

  localparam logic [8:0] REM_ONES = '1;

  // A single-byte bus still needs a 1-bit REM field.
  function automatic int rem_width(int dw);
    return (dw > 8) ? $clog2(dw / 8) : 1;
  endfunction

endpackage

// File: rtl/fl_frame_trim_if.sv
// FrameLink bus bundle.
// master drives the word, slave returns dst_rdy_n.
interface fl_frame_trim_if
  import fl_trim_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  localparam int RW = rem_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] data;
  logic [RW-1:0]         rem;
  logic                  sof_n;
  logic                  eof_n;
  logic                  sop_n;
  logic                  eop_n;
  logic                  src_rdy_n;
  logic                  dst_rdy_n;

  modport master (
    output data, rem,
    output sof_n, eof_n, sop_n, eop_n,
    output src_rdy_n,
    input  dst_rdy_n
  );

  modport slave (
    input  data, rem,
    input  sof_n, eof_n, sop_n, eop_n,
    input  src_rdy_n,
    output dst_rdy_n
  );

endinterface

// File: rtl/fl_trim_outreg.sv
// FrameLink output register: one word, full throughput,
// accepts when empty or when the held word leaves this cycle.
module fl_trim_outreg #(
  parameter int DW = 32,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  input  logic [RW-1:0] in_rem,
  input  logic          in_sof_n,
  input  logic          in_eof_n,
  input  logic          in_sop_n,
  input  logic          in_eop_n,
  output logic [DW-1:0] out_data,
  output logic [RW-1:0] out_rem,
  output logic          out_sof_n,
  output logic          out_eof_n,
  output logic          out_sop_n,
  output logic          out_eop_n,
  output logic          out_src_rdy_n,
  input  logic          out_dst_rdy_n
);

  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [3:0]    flg_q, flg_d;
  logic          load;

  always_comb begin
    in_rdy = !vld_q || !out_dst_rdy_n;
    load   = in_vld && in_rdy;
    data_d = data_q;
    rem_d  = rem_q;
    flg_d  = flg_q;
    vld_d  = vld_q && out_dst_rdy_n;
    if (load) begin
      data_d = in_data;
      rem_d  = in_rem;
      flg_d  = {in_sof_n, in_eof_n, in_sop_n, in_eop_n};
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      rem_q  <= '0;
      flg_q  <= '1;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      rem_q  <= rem_d;
      flg_q  <= flg_d;
    end
  end

  assign out_data      = data_q;
  assign out_rem       = rem_q;
  assign out_sof_n     = flg_q[3];
  assign out_eof_n     = flg_q[2];
  assign out_sop_n     = flg_q[1];
  assign out_eop_n     = flg_q[0];
  assign out_src_rdy_n = !vld_q;

endmodule

// File: rtl/fl_frame_trim.sv
// FrameLink stage that truncates frames to MAX_WORDS words,
// forcing EOF/EOP on the last kept word and counting trims.
module fl_frame_trim
  import fl_trim_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  fl_frame_trim_if.slave       RX,
  fl_frame_trim_if.master      TX,
  output logic [CNT_WIDTH-1:0] TRIM_CNT,
  input  logic                 CNT_CLR
);

  localparam int RW = rem_width(DATA_WIDTH);
  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WORDS);

  state_e               state_q, state_d;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic          or_rdy;
  logic          drop_only;
  logic          acc;
  logic          fwd;
  logic          limit;
  logic [WW-1:0] wnum;
  logic          o_eof_n;
  logic          o_eop_n;
  logic [RW-1:0] o_rem;

  // An SOF word seen in DROP is a new frame and is forwarded.
  assign drop_only = (state_q == DROP) && RX.sof_n;
  assign RX.dst_rdy_n = !(drop_only || or_rdy);

  always_comb begin
    acc = !RX.src_rdy_n && (drop_only || or_rdy);
    fwd = acc && !drop_only;
    if (!RX.sof_n) begin
      wnum = WW'(1);
    end else if (wcnt_q == WMAX) begin
      wnum = WMAX;
    end else begin
      wnum = wcnt_q + WW'(1);
    end
    limit   = fwd && (wnum == WMAX) && RX.eof_n;
    o_eof_n = RX.eof_n && !limit;
    o_eop_n = RX.eop_n && !limit;
    o_rem   = limit ? REM_ONES[RW-1:0] : RX.rem;

    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (fwd) begin
      wcnt_d  = wnum;
      state_d = limit ? DROP : PASS;
    end else if (acc && !RX.eof_n) begin
      wcnt_d  = '0;
      state_d = PASS;
    end

    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (limit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= PASS;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign TRIM_CNT = cnt_q;

  fl_trim_outreg #(
    .DW (DATA_WIDTH),
    .RW (RW)
  ) u_outreg (
    .clk           (CLK),
    .rst_n         (RESET),
    .in_vld        (!RX.src_rdy_n && !drop_only),
    .in_rdy        (or_rdy),
    .in_data       (RX.data),
    .in_rem        (o_rem),
    .in_sof_n      (RX.sof_n),
    .in_eof_n      (o_eof_n),
    .in_sop_n      (RX.sop_n),
    .in_eop_n      (o_eop_n),
    .out_data      (TX.data),
    .out_rem       (TX.rem),
    .out_sof_n     (TX.sof_n),
    .out_eof_n     (TX.eof_n),
    .out_sop_n     (TX.sop_n),
    .out_eop_n     (TX.eop_n),
    .out_src_rdy_n (TX.src_rdy_n),
    .out_dst_rdy_n (TX.dst_rdy_n)
  );

endmodule

// File: tb/tb_fl_frame_trim.sv
// Bench for fl_frame_trim: frame table plus scoreboard,
// with reset and clear-vs-trim sequences.
module tb_fl_frame_trim;
  import fl_trim_pkg::*;

  localparam int DW   = 32;
  localparam int MAXW = 4;
  localparam int CW   = 2;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  rem;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;

  typedef struct {
    int n;
    bit eof;
    int rem_last;
    bit bp;
    bit hl;
    bit clr;
    int clr_at;
    int exp_out;
    int exp_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] trim_cnt;

  int   tests = 0;
  int   fails = 0;
  int   nout = 0;
  int   cyc = 0;
  bit   bp = 1'b0;
  bit   stall = 1'b0;
  bit   in_pass = 1'b0;
  exp_t sbq[$];
  vec_t vecs[12];

  fl_frame_trim_if #(.DATA_WIDTH(DW)) rx_if ();
  fl_frame_trim_if #(.DATA_WIDTH(DW)) tx_if ();

  fl_frame_trim #(
    .DATA_WIDTH (DW),
    .MAX_WORDS  (MAXW),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .RX       (rx_if),
    .TX       (tx_if),
    .TRIM_CNT (trim_cnt),
    .CNT_CLR  (cnt_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    tx_if.dst_rdy_n = 1'b0;
    forever begin
      @(negedge clk);
      tx_if.dst_rdy_n = stall ? 1'b1 : (bp ? ~tx_if.dst_rdy_n : 1'b0);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && !tx_if.src_rdy_n && !tx_if.dst_rdy_n) begin
        nout++;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_extra: got word %0h expected none", tx_if.data);
        end else begin
          e = sbq.pop_front();
          chk("tx_word",
              {tx_if.data, tx_if.rem, tx_if.sof_n, tx_if.eof_n,
               tx_if.sop_n, tx_if.eop_n},
              {e.data, e.rem, e.flg});
          if (!bp) chk("tx_latency", cyc - e.cyc, 1);
        end
      end
      if (bp && in_pass && !rx_if.src_rdy_n &&
          !tx_if.src_rdy_n && tx_if.dst_rdy_n)
        chk("rx_backpressure", rx_if.dst_rdy_n, 1);
    end
  end

  task automatic send_word(int rec, int i, vec_t v);
    logic [3:0] fl;
    logic [1:0] rem;
    bit         last;
    bit         done;
    bit         forced;
    int         stalls;
    exp_t       e;
    last = (i == v.n - 1);
    rem  = last ? 2'(v.rem_last) : 2'(i);
    fl   = {!(i == 0 && !v.hl), !(v.eof && last),
            !(i == 0 || i == 2), !(i == 1 || last)};
    @(negedge clk);
    rx_if.data      = {8'(rec), 24'(i)};
    rx_if.rem       = rem;
    rx_if.sof_n     = fl[3];
    rx_if.eof_n     = fl[2];
    rx_if.sop_n     = fl[1];
    rx_if.eop_n     = fl[0];
    rx_if.src_rdy_n = 1'b0;
    cnt_clr         = (i == v.clr_at);
    in_pass         = (i < MAXW);
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      #4;
      if (!rx_if.dst_rdy_n) done = 1'b1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL rx_timeout: word %0d of rec %0d never accepted", i, rec);
    end else if (i < MAXW) begin
      forced = (i == MAXW - 1) && fl[2];
      e.data = {8'(rec), 24'(i)};
      e.rem  = forced ? 2'd3 : rem;
      e.flg  = forced ? {fl[3], 1'b0, fl[1], 1'b0} : fl;
      e.cyc  = cyc;
      sbq.push_back(e);
    end
    if (i >= MAXW) chk("drop_ready", stalls, 0);
  endtask

  task automatic run_vec(int rec, vec_t v);
    int  n0;
    bit  ok;
    if (v.clr) begin
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
    end
    bp = v.bp;
    n0 = nout;
    for (int i = 0; i < v.n; i++) send_word(rec, i, v);
    @(negedge clk);
    rx_if.src_rdy_n = 1'b1;
    cnt_clr = 1'b0;
    in_pass = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (sbq.size() == 0 && tx_if.src_rdy_n) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: rec %0d left %0d words", rec, sbq.size());
    end
    bp = 1'b0;
    chk("frame_words", nout - n0, v.exp_out);
    chk("trim_cnt", trim_cnt, v.exp_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vr;
    //         n  eof rem bp hl clr at out cnt
    vecs[0]  = '{3,  1, 1, 0, 0, 1, -1, 3, 0};
    vecs[1]  = '{4,  1, 2, 0, 0, 1, -1, 4, 0};
    vecs[2]  = '{10, 1, 0, 0, 0, 1, -1, 4, 1};
    vecs[3]  = '{6,  1, 1, 1, 0, 1, -1, 4, 1};
    vecs[4]  = '{7,  0, 3, 0, 0, 1, -1, 4, 1};
    vecs[5]  = '{2,  1, 1, 0, 0, 0, -1, 2, 1};
    vecs[6]  = '{1,  1, 2, 0, 0, 0, -1, 1, 1};
    vecs[7]  = '{5,  1, 1, 0, 0, 1, -1, 4, 1};
    vecs[8]  = '{5,  1, 1, 0, 0, 0, -1, 4, 2};
    vecs[9]  = '{5,  1, 1, 0, 0, 0, -1, 4, 3};
    vecs[10] = '{5,  1, 1, 0, 0, 0, -1, 4, 3};
    vecs[11] = '{5,  1, 1, 0, 0, 0, -1, 4, 3};

    rx_if.data      = '0;
    rx_if.rem       = '0;
    rx_if.sof_n     = 1'b1;
    rx_if.eof_n     = 1'b1;
    rx_if.sop_n     = 1'b1;
    rx_if.eop_n     = 1'b1;
    rx_if.src_rdy_n = 1'b1;

    #23;
    chk("rst_src_rdy", tx_if.src_rdy_n, 1);
    chk("rst_flags", {tx_if.sof_n, tx_if.eof_n, tx_if.sop_n, tx_if.eop_n}, 4'hf);
    chk("rst_data_rem", {tx_if.data, tx_if.rem}, 0);
    chk("rst_trim_cnt", trim_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 12; r++) run_vec(r, vecs[r]);

    // Reset with a word held and the next one stalled.
    vr = '{8, 1, 1, 0, 0, 0, -1, 0, 0};
    stall = 1'b1;
    send_word(20, 0, vr);
    @(negedge clk);
    rx_if.data      = 32'h1400_0001;
    rx_if.sof_n     = 1'b1;
    rx_if.src_rdy_n = 1'b0;
    #2;
    chk("pre_rst_tx_vld", tx_if.src_rdy_n, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_vld", tx_if.src_rdy_n, 1);
    chk("async_rst_trim_cnt", trim_cnt, 0);
    chk("async_rst_tx_data", tx_if.data, 0);
    sbq.delete();
    @(negedge clk);
    rx_if.src_rdy_n = 1'b1;
    stall = 1'b0;
    rst_n = 1'b1;

    run_vec(21, '{5, 1, 1, 0, 1, 0, -1, 4, 1});
    run_vec(22, '{5, 1, 2, 0, 0, 0, 3, 4, 0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
